// File: rtl/framing_decoding.sv
// Receive-side deframer: hunts preamble+SFD, de-whitens PHR/PSDU with PN9,
// checks the reflected CRC-16 FCS and emits recovered bytes plus frame status.
module framing_decoding #(
  parameter int unsigned PREAMBLE_BYTES = 4,
  parameter logic [7:0]  SFD            = 8'hA7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       serial_in,
  input  logic       serial_in_valid,
  output logic [7:0] phr_psdu_out,
  output logic       phr_psdu_out_valid,
  output logic       frame_done,
  output logic       crc_ok,
  output logic       frame_error
);

  localparam int unsigned SYNC_W  = 8 * (PREAMBLE_BYTES + 1);
  localparam int unsigned PN_W    = 9;
  localparam int unsigned CRC_W   = 16;
  localparam int unsigned LEN_W   = 7;
  localparam int unsigned BIT_W   = 3;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [SYNC_W-1:0] SYNC_PAT = {SFD, {(SYNC_W-8){1'b0}}};
  localparam logic [PN_W-1:0]   PN_SEED  = 9'h1FF;
  localparam logic [CRC_W-1:0]  CRC_POLY = 16'h8408;
  localparam logic [LEN_W-1:0]  MIN_LEN  = 7'd2;

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_PHR    = 2'd1,
    S_PSDU   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SYNC_W-1:0]   sr_q, sr_d;
  logic [PN_W-1:0]     pn_q, pn_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [BYTE_W-1:0]   byte_sr_q, byte_sr_d;
  logic [BYTE_W-1:0]   out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_done_q, frame_done_d;
  logic                crc_ok_q, crc_ok_d;
  logic                frame_error_q, frame_error_d;

  logic                dw_bit_c;
  logic [BYTE_W-1:0]   byte_c;
  logic [SYNC_W-1:0]   sr_shift_c;
  logic [PN_W-1:0]     pn_step_c;
  logic [CRC_W-1:0]    crc_step_c;
  logic                sync_hit_c;
  logic                byte_end_c;
  logic                len_bad_c;
  logic                last_byte_c;

  // Per-bit datapath terms shared by the next-state and output logic
  always_comb begin
    dw_bit_c    = serial_in ^ pn_q[0];
    byte_c      = {dw_bit_c, byte_sr_q[BYTE_W-1:1]};
    sr_shift_c  = {serial_in, sr_q[SYNC_W-1:1]};
    pn_step_c   = {pn_q[0] ^ pn_q[5], pn_q[PN_W-1:1]};
    crc_step_c  = (crc_q >> 1) ^ ((dw_bit_c ^ crc_q[0]) ? CRC_POLY : '0);
    sync_hit_c  = (state_q == S_SEARCH) && serial_in_valid && (sr_shift_c == SYNC_PAT);
    byte_end_c  = serial_in_valid && (bit_cnt_q == 3'd7);
    len_bad_c   = byte_c[LEN_W-1:0] < MIN_LEN;
    last_byte_c = byte_cnt_q == 7'd1;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_SEARCH;
      sr_q          <= '0;
      pn_q          <= '0;
      crc_q         <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      byte_sr_q     <= '0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      frame_done_q  <= 1'b0;
      crc_ok_q      <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      pn_q          <= pn_d;
      crc_q         <= crc_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      byte_sr_q     <= byte_sr_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      frame_done_q  <= frame_done_d;
      crc_ok_q      <= crc_ok_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SEARCH: if (sync_hit_c) state_d = S_PHR;
      S_PHR:    if (byte_end_c) state_d = len_bad_c ? S_SEARCH : S_PSDU;
      S_PSDU:   if (byte_end_c && last_byte_c) state_d = S_DONE;
      S_DONE:   state_d = S_SEARCH;
      default:  state_d = S_SEARCH;
    endcase
  end

  // Datapath and output next values; status outputs are single-cycle pulses
  always_comb begin
    sr_d          = sr_q;
    pn_d          = pn_q;
    crc_d         = crc_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    byte_sr_d     = byte_sr_q;
    out_d         = out_q;
    out_valid_d   = 1'b0;
    frame_done_d  = 1'b0;
    crc_ok_d      = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      S_SEARCH: begin
        if (serial_in_valid) begin
          sr_d = sr_shift_c;
          if (sync_hit_c) begin
            pn_d      = PN_SEED;
            crc_d     = '0;
            bit_cnt_d = '0;
            byte_sr_d = '0;
          end
        end
      end

      S_PHR: begin
        if (serial_in_valid) begin
          pn_d      = pn_step_c;
          byte_sr_d = byte_c;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_end_c) begin
            out_d       = byte_c;
            out_valid_d = 1'b1;
            if (len_bad_c) begin
              frame_error_d = 1'b1;
              sr_d          = '0;
            end else begin
              byte_cnt_d = byte_c[LEN_W-1:0];
            end
          end
        end
      end

      S_PSDU: begin
        if (serial_in_valid) begin
          pn_d      = pn_step_c;
          crc_d     = crc_step_c;
          byte_sr_d = byte_c;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_end_c) begin
            out_d       = byte_c;
            out_valid_d = 1'b1;
            byte_cnt_d  = byte_cnt_q - 7'd1;
          end
        end
      end

      S_DONE: begin
        frame_done_d = 1'b1;
        crc_ok_d     = (crc_q == '0);
        // A bit arriving here already belongs to the next frame's preamble
        sr_d = serial_in_valid ? {serial_in, {(SYNC_W-1){1'b0}}} : '0;
      end

      default: begin
        sr_d = '0;
      end
    endcase
  end

  assign phr_psdu_out       = out_q;
  assign phr_psdu_out_valid = out_valid_q;
  assign frame_done         = frame_done_q;
  assign crc_ok             = crc_ok_q;
  assign frame_error        = frame_error_q;

endmodule
